// File: rtl/mar_ram_unit.sv
// Memory stage: MAR, MDR and a 2^ADDR_W x DATA_W RAM driven by active-low control strobes.
// Includes a host program-load port and an optional sweep that zeroes the RAM after reset.
module mar_ram_unit #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 4,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mar_addr_load_n,
  input  logic              mar_mem_load_n,
  input  logic              ram_en_n,
  input  logic              ram_load_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic              ready,
  output logic [ADDR_W-1:0] mar_q,
  output logic [DATA_W-1:0] mdr_q
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              cmd_en;
  logic              prog_en;

  assign cmd_en  = ready && (state == ST_RUN) && !prog_mode;
  assign prog_en = ready && (state == ST_RUN) && prog_mode;

  // Control state: clear sweep, then MAR/MDR loads while running
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      ptr   <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          ptr <= ptr + ADDR_W'(1);
          if (ptr == {ADDR_W{1'b1}}) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        default: begin
          ready <= 1'b1;
          if (cmd_en) begin
            if (!mar_addr_load_n) mar_q <= bus_in[ADDR_W-1:0];
            if (!mar_mem_load_n)  mdr_q <= bus_in;
          end
        end
      endcase
    end
  end

  // RAM write port; a store always uses the pre-edge MAR and MDR
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem[ptr] <= '0;
      end else if (prog_en && prog_we) begin
        mem[prog_addr] <= prog_data;
      end else if (cmd_en && !ram_load_n) begin
        mem[mar_q] <= mdr_q;
      end
    end
  end

  // Zero-latency read so the consumer captures the word at the next edge
  assign bus_drive = cmd_en && !ram_en_n;
  assign bus_out   = bus_drive ? mem[mar_q] : '0;

endmodule

// File: tb/tb_mar_ram_unit.sv
// Self-checking bench for mar_ram_unit: reference RAM model plus a queue of expected bus reads.
module tb_mar_ram_unit;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              mar_addr_load_n, mar_mem_load_n, ram_en_n, ram_load_n;
  logic [DATA_W-1:0] bus_in;
  logic              prog_mode, prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] bus_out;
  logic              bus_drive, ready;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] sb_q [$];

  mar_ram_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .mar_addr_load_n(mar_addr_load_n), .mar_mem_load_n(mar_mem_load_n),
    .ram_en_n(ram_en_n), .ram_load_n(ram_load_n), .bus_in(bus_in),
    .prog_mode(prog_mode), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .bus_out(bus_out), .bus_drive(bus_drive), .ready(ready), .mar_q(mar_q), .mdr_q(mdr_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mar_addr_load_n = 1'b1; mar_mem_load_n = 1'b1; ram_en_n = 1'b1; ram_load_n = 1'b1;
    prog_mode = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; bus_in = '0;
  endtask

  // Counts edges until ready rises; the clear must take exactly DEPTH edges
  task automatic wait_ready(input string tag);
    int n = 0;
    check({tag, "_ready_low"}, 32'(ready), 32'd0);
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_clear_len"}, 32'(n), 32'(DEPTH));
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic prog_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    prog_mode = 1'b1; prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0; prog_mode = 1'b0;
    model[a] = d;
  endtask

  task automatic load_mar(input logic [DATA_W-1:0] v);
    mar_addr_load_n = 1'b0; bus_in = v;
    tick();
    mar_addr_load_n = 1'b1;
  endtask

  task automatic load_mdr(input logic [DATA_W-1:0] v);
    mar_mem_load_n = 1'b0; bus_in = v;
    tick();
    mar_mem_load_n = 1'b1;
  endtask

  // Expected word is queued as \CE is driven and popped when the DUT drives the bus
  task automatic ce_read(input string tag, input logic [ADDR_W-1:0] a);
    sb_q.push_back(model[a]);
    ram_en_n = 1'b0;
    #1;
    check({tag, "_drive"}, 32'(bus_drive), 32'd1);
    if (sb_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
    else check({tag, "_data"}, 32'(bus_out), 32'(sb_q.pop_front()));
    tick();
    ram_en_n = 1'b1;
  endtask

  task automatic read_addr(input string tag, input logic [ADDR_W-1:0] a);
    load_mar(DATA_W'(a));
    ce_read(tag, a);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_mar", 32'(mar_q), 32'd0);
    check("rst_mdr", 32'(mdr_q), 32'd0);
    check("rst_drive", 32'(bus_drive), 32'd0);

    // Commands and program writes during the clear must be ignored
    rst = 1'b0;
    prog_we = 1'b1; prog_addr = 4'd5; prog_data = 8'h77;
    mar_addr_load_n = 1'b0; mar_mem_load_n = 1'b0; ram_load_n = 1'b0; ram_en_n = 1'b0;
    bus_in = 8'h05;
    #1;
    check("clear_drive", 32'(bus_drive), 32'd0);
    check("clear_bus", 32'(bus_out), 32'd0);
    wait_ready("init");
    idle();
    check("clear_mar", 32'(mar_q), 32'd0);
    check("clear_mdr", 32'(mdr_q), 32'd0);
    for (int i = 0; i < int'(DEPTH); i++) read_addr("init_zero", ADDR_W'(i));

    // Fill with 0xAB, reset once, the clear must wipe it again
    for (int i = 0; i < int'(DEPTH); i++) prog_write(ADDR_W'(i), 8'hAB);
    read_addr("fill", 4'd7);
    pulse_reset();
    wait_ready("refill");
    for (int i = 0; i < int'(DEPTH); i++) read_addr("wiped", ADDR_W'(i));

    // Fetch read: upper bus bits ignored by MAR
    prog_write(4'd3, 8'h2E);
    load_mar(8'hF3);
    check("fetch_mar", 32'(mar_q), 32'h3);
    ce_read("fetch", 4'd3);
    #1;
    check("idle_bus", 32'(bus_out), 32'd0);
    check("idle_drive", 32'(bus_drive), 32'd0);

    // STA path
    load_mar(8'h0A);
    load_mdr(8'h55);
    check("sta_mdr", 32'(mdr_q), 32'h55);
    ram_load_n = 1'b0;
    tick();
    ram_load_n = 1'b1;
    model[10] = 8'h55;
    ce_read("sta", 4'd10);

    // Store with simultaneous MAR/MDR loads uses the old address and data
    load_mdr(8'h11);
    load_mar(8'h02);
    ram_load_n = 1'b0; mar_mem_load_n = 1'b0; mar_addr_load_n = 1'b0; bus_in = 8'h99;
    tick();
    idle();
    model[2] = 8'h11;
    check("simul_mdr", 32'(mdr_q), 32'h99);
    check("simul_mar", 32'(mar_q), 32'h9);
    read_addr("simul_ram2", 4'd2);
    read_addr("simul_ram9", 4'd9);

    // \CE with \L_R shows the old word; new word appears next read
    load_mar(8'h04);
    load_mdr(8'h3C);
    ram_load_n = 1'b0;
    ce_read("ce_lr_old", 4'd4);
    ram_load_n = 1'b1;
    model[4] = 8'h3C;
    ce_read("ce_lr_new", 4'd4);

    // \CE with \L_MA reads through the old MAR
    mar_addr_load_n = 1'b0; bus_in = 8'h07;
    ce_read("ce_lma", 4'd4);
    mar_addr_load_n = 1'b1;
    check("ce_lma_mar", 32'(mar_q), 32'h7);

    // Program mode in RUN blocks the control strobes
    prog_mode = 1'b1; mar_mem_load_n = 1'b0; mar_addr_load_n = 1'b0; ram_en_n = 1'b0;
    ram_load_n = 1'b0; bus_in = 8'hEE;
    #1;
    check("prog_drive", 32'(bus_drive), 32'd0);
    tick();
    idle();
    check("prog_mdr", 32'(mdr_q), 32'h3C);
    check("prog_mar", 32'(mar_q), 32'h7);
    read_addr("prog_ram7", 4'd7);

    // Reset in the middle of a clear restarts the full sweep
    load_mdr(8'h42);
    pulse_reset();
    for (int i = 0; i < 8; i++) tick();
    check("mid_ready", 32'(ready), 32'd0);
    pulse_reset();
    wait_ready("mid");
    check("mid_mar", 32'(mar_q), 32'd0);
    check("mid_mdr", 32'(mdr_q), 32'd0);
    read_addr("mid_ram4", 4'd4);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mar_ram_unit.md
Name: mar_ram_unit

Overview:
- Memory stage driven directly by the control block's registered active-low signals \L_MA, \L_MD, \CE and \L_R.
- Holds the memory address register (MAR), the memory data register (MDR) and a 2^ADDR_W x DATA_W RAM.
- Drives the shared bus on instruction fetch and operand reads, and stores register-A contents on STA.
- Has a program-load port for host preloading, and an automatic RAM clear after reset.

Parameters:
DATA_W, 8, bus/RAM word width
ADDR_W, 4, MAR width; RAM depth = 2^ADDR_W
CLEAR_ON_RESET, 1, 1 = zero all RAM words after reset; 0 = RAM contents retained

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
mar_addr_load_n  input  1  \L_MA: MAR <= bus_in[ADDR_W-1:0]
mar_mem_load_n  input  1  \L_MD: MDR <= bus_in
ram_en_n  input  1  \CE: RAM[MAR] drives bus
ram_load_n  input  1  \L_R: RAM[MAR] <= MDR
bus_in  input  DATA_W  shared bus value
prog_mode  input  1  1 = host program-load mode
prog_we  input  1  program write strobe
prog_addr  input  ADDR_W  program write address
prog_data  input  DATA_W  program write data
bus_out  output  DATA_W  RAM read data; 0 when not driving
bus_drive  output  1  1 = bus_out valid for bus mux
ready  output  1  1 = clear finished, unit accepts commands
mar_q  output  ADDR_W  current MAR (debug)
mdr_q  output  DATA_W  current MDR (debug)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. No asynchronous logic.
- Reset (edge with rst=1):
  - mar_q=0, mdr_q=0, clear pointer=0, ready=0.
  - State goes to CLEAR if CLEAR_ON_RESET=1, else RUN.
  - RAM is not touched on the rst=1 edge itself.
- bus_out=0 and bus_drive=0 whenever ready=0.
- States: CLEAR and RUN.
- CLEAR:
  - Each edge with rst=0: RAM[ptr] <= 0, ptr <= ptr+1.
  - On the edge that writes address 2^ADDR_W-1: state <= RUN, ready <= 1.
  - ready therefore rises after exactly 2^ADDR_W edges with rst low (16 at default).
  - All control inputs and the program port are ignored.
- CLEAR_ON_RESET=0: ready <= 1 on the first edge with rst=0 after reset.
- RUN, prog_mode=1:
  - Control inputs ignored; bus_drive=0.
  - prog_we=1 at an edge: RAM[prog_addr] <= prog_data.
  - MAR and MDR hold their values.
- RUN, prog_mode=0, all actions on the same edge:
  - mar_addr_load_n=0: MAR <= bus_in[ADDR_W-1:0]; upper bus bits are ignored.
  - mar_mem_load_n=0: MDR <= bus_in.
  - ram_load_n=0: RAM[MAR] <= MDR.
  - ram_en_n=0: bus_drive=1 and bus_out=RAM[MAR], combinationally in the same cycle. Zero read latency: the control block's registered \CE and \IR_LOAD_N are asserted in the same cycle, so IR/regA/regB capture the value at the next edge.
- Simultaneous events:
  - A write uses the pre-edge MAR and MDR. If \L_R is issued together with \L_MA or \L_MD, the old address/data are written, and the new ones take effect next cycle.
  - \CE together with \L_R: bus_out shows the old word this cycle; the new word is stored at the edge.
  - \CE together with \L_MA: the read uses the old MAR.
- Reset mid-CLEAR or mid-RUN: the clear restarts from address 0, with the full 2^ADDR_W cycles again.
- Address arithmetic wraps modulo 2^ADDR_W. There are no out-of-range conditions.

Test Plan:
- Clear timing: prog-write 0xAB to every address, pulse rst for 1 edge → ready=0 for exactly 16 edges, then 1. Each read via \L_MA then \CE → bus_out=0x00, bus_drive=1.
- Fetch read: prog-write 0x2E at addr 3, leave prog mode; bus_in=0xF3 with \L_MA=0 → mar_q=0x3. Next cycle \CE=0 → bus_out=0x2E, bus_drive=1 in that cycle. With \CE=1 → bus_out=0x00, bus_drive=0.
- STA path:
  - Step 1: bus_in=0x0A with \L_MA=0.
  - Step 2: bus_in=0x55 with \L_MD=0.
  - Step 3: \L_R=0.
  - Step 4: \CE=0 → bus_out=0x55.
- Simultaneous: mdr_q=0x11, mar_q=0x2. One edge with \L_R=0, \L_MD=0, \L_MA=0, bus_in=0x99 → RAM[2]=0x11, mdr_q=0x99, mar_q=0x9.
- Ignored inputs: during CLEAR, drive prog_we=1 and \L_MA=0 with bus_in=0x05 → mar_q stays 0 and RAM stays all-zero. Repeat with prog_mode=1 in RUN and \L_MD=0 → mdr_q unchanged, bus_drive=0.
- Reset mid-clear: assert rst at edge 8 of CLEAR → ready stays 0 for a further 16 edges after rst drops; mar_q=0, mdr_q=0.
